des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//  Iterative DES key schedule, directly upstream of the round stage: produces one 48-bit subkey per
//  handshake, K1..K16 for encrypt or K16..K1 for decrypt, from a 64-bit key loaded on start.
//  Holds C/D (28+28 b) in registers and rotates one round per accepted subkey, so no 16x48 key
//  table is stored. Bit order: FIPS 46-3 bit 1 = MSB (key_i[63], round_key_o[47]).
// PARAMETERS
//  CHECK_PARITY  1  1 = evaluate odd parity of each key byte at start; 0 = parity_err_o tied 0
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   reset, asynchronous, active-low
//  start_i         in   1   load key and begin schedule; accepted only in IDLE
//  decrypt_i       in   1   0 = K1..K16 order, 1 = K16..K1; sampled with start_i
//  key_i           in   64  DES key incl. parity bits (bits 8,16..64 FIPS); sampled with start_i
//  ready_i         in   1   consumer takes current subkey this cycle
//  busy_o          out  1   schedule in progress (state RUN)
//  subkey_valid_o  out  1   round_key_o valid
//  round_o         out  4   round index of current subkey, 0..15 = round 1..16 of the cipher
//  round_key_o     out  48  PC-2(C,D), driven 0 when subkey_valid_o = 0
//  last_o          out  1   current subkey is the 16th of the schedule (valid && round_o==15)
//  parity_err_o    out  1   registered at start: some key byte has even parity; held until next start
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, C/D=0, round=0, parity_err=0; all outputs 0.
//  States: IDLE -> RUN on start_i; RUN -> IDLE on handshake (valid && ready_i) with round_o==15.
//  Shift table s[r], r=1..16: 1 for r=1,2,9,16, else 2.
//  Start edge (IDLE, start_i=1): {C,D} <= PC-1(key_i), then
//   encrypt: C,D rotl by s[1]=1 -> current = K1; decrypt: no rotation -> current = K16 (sum s = 28).
//   round <= 0, parity_err <= CHECK_PARITY && any byte XOR-reduces to 0.
//  Latency: first subkey valid the cycle after start accepted; 16 subkeys back-to-back if ready_i=1.
//  RUN: subkey_valid_o=1, busy_o=1; round_key_o = PC-2(C,D) from registers (stable while stalled).
//  Handshake edge (ready_i=1) with round_o=n<15: round <= n+1;
//   encrypt: C,D rotl by s[n+2] (K(n+1) -> K(n+2));
//   decrypt: C,D rotr by s[16-n] (K(16-n) -> K(15-n)).
//  ready_i=0 in RUN: C, D, round and outputs hold unchanged, indefinitely.
//  Final handshake (round_o=15): -> IDLE; C/D cleared to 0; valid, busy, last drop next cycle.
//  start_i in RUN (incl. the final-handshake cycle) is ignored; key_i/decrypt_i changes in RUN
//   have no effect. Back-to-back schedules need one IDLE cycle.
//  Rotation is within each 28-bit half only; no carry between C and D.
//  Reset asserted mid-schedule: immediate return to IDLE state/outputs, no partial output afterwards.
//  Parity is status only: a key with parity_err_o=1 is still scheduled normally.
// TESTING
//  1 key 133457799BBCDFF1, decrypt 0, ready 1 -> K1=1B02EFFC7072 one cycle after start,
//    16 consecutive valids, round_o 0..15, K16=CB3D8B0E17F5 with last_o=1, parity_err_o=0.
//  2 same key, decrypt 1 -> first subkey CB3D8B0E17F5, last 1B02EFFC7072; full sequence equals
//    the reverse of scenario 1 (compare all 16 against a reference model).
//  3 scenario 1 with ready_i low 3 cycles at round_o=4 -> round_key_o/round_o frozen 3 cycles,
//    sequence identical to scenario 1, total 19 valid cycles.
//  4 start_i pulsed with new key at round_o=7 and on final handshake -> ignored, sequence
//    unchanged; start one cycle after return to IDLE -> accepted.
//  5 key 0000000000000000 -> parity_err_o=1 (CHECK_PARITY=1), all 16 subkeys 000000000000;
//    CHECK_PARITY=0 -> parity_err_o=0.
//  6 rst_n low at round_o=9 -> next cycle all outputs 0, IDLE; subsequent start runs clean K1..K16.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// des_key_schedule_if
//  Bundles the request side of the DES key schedule with its subkey stream.
//  The requester (master) loads a key, picks the schedule direction and
//  paces the subkeys with ready_i. The key schedule (slave) returns one
//  48-bit subkey per handshake, together with its round index and status.
//  Signals:
//    start_i         load key_i/decrypt_i and begin a schedule
//    decrypt_i       0 = K1..K16, 1 = K16..K1
//    key_i           64-bit DES key including parity bits
//    ready_i         consumer takes the current subkey this cycle
//    busy_o          schedule in progress
//    subkey_valid_o  round_key_o holds a valid subkey
//    round_o         round index of the current subkey (0..15)
//    round_key_o     current 48-bit subkey, 0 when not valid
//    last_o          current subkey is the 16th of the schedule
//    parity_err_o    some byte of the last loaded key had even parity
interface des_key_schedule_if;
  logic        start_i;
  logic        decrypt_i;
  logic [63:0] key_i;
  logic        ready_i;
  logic        busy_o;
  logic        subkey_valid_o;
  logic [3:0]  round_o;
  logic [47:0] round_key_o;
  logic        last_o;
  logic        parity_err_o;

  modport master (
    output start_i, decrypt_i, key_i, ready_i,
    input  busy_o, subkey_valid_o, round_o, round_key_o, last_o, parity_err_o
  );

  modport slave (
    input  start_i, decrypt_i, key_i, ready_i,
    output busy_o, subkey_valid_o, round_o, round_key_o, last_o, parity_err_o
  );
endinterface

// File: rtl/des_key_schedule.sv
// des_key_schedule
//  Iterative DES key schedule. On start the 64-bit key is reduced by PC-1
//  to the 28-bit halves C and D; every accepted subkey rotates C and D by
//  one round's shift, so only C/D are stored rather than a table of all
//  sixteen subkeys. The current subkey is PC-2(C,D) taken straight from the
//  registers, which keeps it stable while the consumer stalls.
//  Bit order follows FIPS 46-3: bit 1 is the MSB of every vector.
//  Parameters:
//    CHECK_PARITY  1 = flag keys with an even-parity byte, 0 = flag tied low
//  Ports:
//    clk    clock, all state updates on the rising edge
//    rst_n  asynchronous active-low reset
//    bus    request / subkey stream interface (slave side)
module des_key_schedule #(
  parameter bit CHECK_PARITY = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  des_key_schedule_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // FIPS bit numbers (1 = MSB of the source vector) for each output bit.
  localparam logic [5:0] PC1_TABLE [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TABLE [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int j = 0; j < 56; j++) begin
      cd[6'(55 - j)] = key[6'(7'd64 - {1'b0, PC1_TABLE[j]})];
    end
    return cd;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] rk;
    rk = '0;
    for (int j = 0; j < 48; j++) begin
      rk[6'(47 - j)] = cd[6'(7'd56 - {1'b0, PC2_TABLE[j]})];
    end
    return rk;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one position, all others by two.
  function automatic logic shift_is_one(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic by_one);
    return by_one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic by_one);
    return by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // DES keys carry odd parity per byte; any byte XOR-reducing to 0 is bad.
  function automatic logic parity_bad(input logic [63:0] key);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (^key[i*8 +: 8] == 1'b0) bad = 1'b1;
    end
    return bad;
  endfunction

  state_t      state, state_next;
  logic [27:0] c_reg, c_next;
  logic [27:0] d_reg, d_next;
  logic [3:0]  round_reg, round_next;
  logic        dec_reg, dec_next;
  logic        par_reg, par_next;
  logic [55:0] loaded_cd;
  logic [4:0]  enc_round;
  logic [4:0]  dec_round;

  // State and C/D registers; reset clears everything so no partial
  // schedule can leak out after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      round_reg <= '0;
      dec_reg   <= 1'b0;
      par_reg   <= 1'b0;
    end else begin
      state     <= state_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      round_reg <= round_next;
      dec_reg   <= dec_next;
      par_reg   <= par_next;
    end
  end

  // Schedule round numbers of the rotation that moves to the next subkey:
  // encrypt goes K(n+1) -> K(n+2) by rotating left s[n+2]; decrypt undoes
  // round 16-n by rotating right s[16-n].
  assign loaded_cd = pc1(bus.key_i);
  assign enc_round = 5'({1'b0, round_reg} + 5'd2);
  assign dec_round = 5'(5'd16 - {1'b0, round_reg});

  // Next-state logic. Encrypt pre-applies round 1's shift at load so K1 is
  // presented immediately; decrypt loads without rotation because the
  // sixteen shifts sum to 28, leaving C16/D16 equal to C0/D0.
  always_comb begin
    state_next = state;
    c_next     = c_reg;
    d_next     = d_reg;
    round_next = round_reg;
    dec_next   = dec_reg;
    par_next   = par_reg;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_next = RUN;
          dec_next   = bus.decrypt_i;
          round_next = '0;
          par_next   = CHECK_PARITY && parity_bad(bus.key_i);
          if (bus.decrypt_i) begin
            c_next = loaded_cd[55:28];
            d_next = loaded_cd[27:0];
          end else begin
            c_next = rotl(loaded_cd[55:28], 1'b1);
            d_next = rotl(loaded_cd[27:0], 1'b1);
          end
        end
      end
      RUN: begin
        if (bus.ready_i) begin
          if (round_reg == 4'd15) begin
            state_next = IDLE;
            c_next     = '0;
            d_next     = '0;
            round_next = '0;
          end else begin
            round_next = round_reg + 4'd1;
            if (dec_reg) begin
              c_next = rotr(c_reg, shift_is_one(dec_round));
              d_next = rotr(d_reg, shift_is_one(dec_round));
            end else begin
              c_next = rotl(c_reg, shift_is_one(enc_round));
              d_next = rotl(d_reg, shift_is_one(enc_round));
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy_o         = (state == RUN);
  assign bus.subkey_valid_o = (state == RUN);
  assign bus.round_o        = round_reg;
  assign bus.round_key_o    = (state == RUN) ? pc2({c_reg, d_reg}) : 48'd0;
  assign bus.last_o         = (state == RUN) && (round_reg == 4'd15);
  assign bus.parity_err_o   = par_reg;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule
//  Self-checking bench for des_key_schedule. Known FIPS vectors come from a
//  table; every schedule is also compared against a reference model that
//  computes each subkey directly from the cumulative shift count.
module tb_des_key_schedule;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  des_key_schedule_if bus ();
  des_key_schedule_if bus_np ();

  des_key_schedule #(.CHECK_PARITY(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  des_key_schedule #(.CHECK_PARITY(1'b0)) dut_np (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_np)
  );

  int checks = 0;
  int errors = 0;

  localparam int PC1_REF [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
  };

  localparam int PC2_REF [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef struct {
    logic [63:0] key;
    bit          dec;
    logic [47:0] first;
    logic [47:0] last;
    bit          parity;
  } vec_t;

  vec_t vecs [5];
  logic [47:0] exp_seq [16];

  // Subkey K(r) computed from scratch: C0/D0 rotated left by the total
  // number of positions shifted through rounds 1..r, then PC-2.
  function automatic logic [47:0] model_subkey(input logic [63:0] key, input int r);
    bit c [28];
    bit d [28];
    int total;
    int p;
    logic [47:0] sk;
    for (int j = 0; j < 28; j++) begin
      c[j] = key[64 - PC1_REF[j]];
      d[j] = key[64 - PC1_REF[28 + j]];
    end
    total = 0;
    for (int i = 1; i <= r; i++) total += (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
    sk = '0;
    for (int k = 0; k < 48; k++) begin
      p = PC2_REF[k];
      sk[47 - k] = (p <= 28) ? c[(p - 1 + total) % 28] : d[(p - 29 + total) % 28];
    end
    return sk;
  endfunction

  function automatic bit model_parity_err(input logic [63:0] key);
    int ones;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(key[b*8 + i]);
      if (ones % 2 == 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Present a start request; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [63:0] key, input bit dec);
    bus.key_i     = key;
    bus.decrypt_i = dec;
    bus.start_i   = 1'b1;
    bus.ready_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Runs one full schedule and checks every valid cycle against the model.
  // stall_at/stall_len hold ready_i low at a round; pulse_at/pulse_final
  // drive a rogue start with a different key while busy.
  task automatic runSchedule(input string tag, input logic [63:0] key, input bit dec,
                             input int stall_at, input int stall_len,
                             input int pulse_at, input bit pulse_final, input bit exp_par,
                             output int valid_cycles, output logic [47:0] got_first,
                             output logic [47:0] got_last);
    int idx;
    int stalled;
    int cycles;
    for (int i = 0; i < 16; i++) exp_seq[i] = dec ? model_subkey(key, 16 - i) : model_subkey(key, i + 1);
    applyStimulus(key, dec);
    checkOutput({tag, " parity_err"}, 64'(bus.parity_err_o), 64'(exp_par));
    idx = 0;
    stalled = 0;
    cycles = 0;
    valid_cycles = 0;
    got_first = 'x;
    got_last = 'x;
    while (idx < 16 && cycles < 100) begin
      cycles++;
      checkOutput({tag, " valid"}, 64'(bus.subkey_valid_o), 64'd1);
      if (bus.subkey_valid_o === 1'b1) valid_cycles++;
      checkOutput({tag, " busy"}, 64'(bus.busy_o), 64'd1);
      checkOutput($sformatf("%s round_o@%0d", tag, idx), 64'(bus.round_o), 64'(idx));
      checkOutput($sformatf("%s subkey@%0d", tag, idx), 64'(bus.round_key_o), 64'(exp_seq[idx]));
      checkOutput($sformatf("%s last@%0d", tag, idx), 64'(bus.last_o), 64'(idx == 15));
      if (idx == 0) got_first = bus.round_key_o;
      if (idx == 15) got_last = bus.round_key_o;
      bus.start_i   = (idx == pulse_at) || (pulse_final && idx == 15);
      bus.key_i     = ~key;
      bus.decrypt_i = ~dec;
      if (idx == stall_at && stalled < stall_len) begin
        bus.ready_i = 1'b0;
        stalled++;
      end else begin
        bus.ready_i = 1'b1;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    if (idx < 16) checkOutput({tag, " timeout"}, 64'(idx), 64'd16);
    bus.start_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.key_i   = key;
    checkOutput({tag, " idle valid"}, 64'(bus.subkey_valid_o), 64'd0);
    checkOutput({tag, " idle busy"}, 64'(bus.busy_o), 64'd0);
    checkOutput({tag, " idle last"}, 64'(bus.last_o), 64'd0);
    checkOutput({tag, " idle key"}, 64'(bus.round_key_o), 64'd0);
    checkOutput({tag, " parity held"}, 64'(bus.parity_err_o), 64'(exp_par));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vc;
    logic [47:0] f;
    logic [47:0] l;
    logic [63:0] rkey;
    bit rdec;
    int sa;
    int sl;

    vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 1'b0};
    vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 1'b0};
    vecs[2] = '{64'h0000000000000000, 1'b0, 48'h000000000000, 48'h000000000000, 1'b1};
    vecs[3] = '{64'hFEFEFEFEFEFEFEFE, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b0};
    vecs[4] = '{64'h0101010101010101, 1'b0, 48'h000000000000, 48'h000000000000, 1'b0};

    bus.start_i = 1'b0;
    bus.decrypt_i = 1'b0;
    bus.key_i = '0;
    bus.ready_i = 1'b0;
    bus_np.start_i = 1'b0;
    bus_np.decrypt_i = 1'b0;
    bus_np.key_i = '0;
    bus_np.ready_i = 1'b0;

    // Reset state
    #12;
    checkOutput("reset valid", 64'(bus.subkey_valid_o), 64'd0);
    checkOutput("reset busy", 64'(bus.busy_o), 64'd0);
    checkOutput("reset round", 64'(bus.round_o), 64'd0);
    checkOutput("reset key", 64'(bus.round_key_o), 64'd0);
    checkOutput("reset last", 64'(bus.last_o), 64'd0);
    checkOutput("reset parity", 64'(bus.parity_err_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known vectors, back-to-back schedules with ready held high
    for (int v = 0; v < 5; v++) begin
      runSchedule($sformatf("vec%0d", v), vecs[v].key, vecs[v].dec, -1, 0, -1, 1'b0,
                  vecs[v].parity, vc, f, l);
      checkOutput($sformatf("vec%0d first", v), 64'(f), 64'(vecs[v].first));
      checkOutput($sformatf("vec%0d last", v), 64'(l), 64'(vecs[v].last));
      checkOutput($sformatf("vec%0d valid cycles", v), 64'(vc), 64'd16);
    end

    // Parity checking disabled: zero key still flags nothing
    bus_np.key_i = '0;
    bus_np.start_i = 1'b1;
    bus_np.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus_np.start_i = 1'b0;
    checkOutput("noparity parity_err", 64'(bus_np.parity_err_o), 64'd0);
    checkOutput("noparity valid", 64'(bus_np.subkey_valid_o), 64'd1);
    checkOutput("noparity subkey", 64'(bus_np.round_key_o), 64'd0);

    // Stall three cycles at round 4
    runSchedule("stall", 64'h133457799BBCDFF1, 1'b0, 4, 3, -1, 1'b0, 1'b0, vc, f, l);
    checkOutput("stall valid cycles", 64'(vc), 64'd19);

    // Rogue starts mid-schedule and on the final handshake are ignored,
    // then a start right after returning to IDLE is accepted
    runSchedule("rogue", 64'h133457799BBCDFF1, 1'b0, -1, 0, 7, 1'b1, 1'b0, vc, f, l);
    checkOutput("rogue valid cycles", 64'(vc), 64'd16);
    runSchedule("after_rogue", 64'h133457799BBCDFF1, 1'b1, -1, 0, -1, 1'b0, 1'b0, vc, f, l);
    checkOutput("after_rogue first", 64'(f), 64'h0000CB3D8B0E17F5);

    // Reset mid-schedule at round 9
    applyStimulus(64'h133457799BBCDFF1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort round before reset", 64'(bus.round_o), 64'd9);
    bus.ready_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort valid", 64'(bus.subkey_valid_o), 64'd0);
    checkOutput("abort busy", 64'(bus.busy_o), 64'd0);
    checkOutput("abort round", 64'(bus.round_o), 64'd0);
    checkOutput("abort key", 64'(bus.round_key_o), 64'd0);
    checkOutput("abort last", 64'(bus.last_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runSchedule("post_abort", 64'h133457799BBCDFF1, 1'b0, -1, 0, -1, 1'b0, 1'b0, vc, f, l);
    checkOutput("post_abort first", 64'(f), 64'h00001B02EFFC7072);
    checkOutput("post_abort last", 64'(l), 64'h0000CB3D8B0E17F5);

    // Random keys, directions and stalls against the model
    for (int t = 0; t < 6; t++) begin
      rkey = {$urandom, $urandom};
      rdec = 1'($urandom_range(0, 1));
      sa = $urandom_range(0, 15);
      sl = $urandom_range(0, 3);
      runSchedule($sformatf("rand%0d", t), rkey, rdec, sa, sl, -1, 1'b0,
                  model_parity_err(rkey), vc, f, l);
      checkOutput($sformatf("rand%0d valid cycles", t), 64'(vc), 64'(16 + sl));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
